mult_pipe_elastic: RTL and testbench

//  Parametrised, DSP-mapped A_W x B_W multiplier with an elastic valid/ready pipeline,

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_core.sv | 23 ++
 rtl/mult_pipe_elastic.sv | 122 ++++++++++++
 tb/tb_mult_pipe_elastic.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the elastic multiplier pipeline.
// Slot type and extension helper are sized for the default operand/accumulator widths.
package mult_pkg;

    localparam int A_W    = 17;
    localparam int B_W    = 17;
    localparam int ACC_W  = 48;
    localparam int PROD_W = A_W + B_W;

    // Product travels already extended to accumulator width.
    typedef struct packed {
        logic [ACC_W-1:0] prod;
        logic             sgn;
        logic             acc;
    } slot_t;

    function automatic logic [ACC_W-1:0] sext_to(input logic [PROD_W-1:0] p,
                                                 input logic              sgn);
        return {{(ACC_W-PROD_W){sgn & p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/mult_core.sv
// Combinational signed/unsigned multiplier; all registers live in the caller.
// Operands are extended to the full product width so the low bits are exact in both modes.
(* use_dsp = "yes" *)
module mult_core #(
    parameter int A_W = 17,
    parameter int B_W = 17
) (
    input  logic [A_W-1:0]     a_i,
    input  logic [B_W-1:0]     b_i,
    input  logic               sgn_i,
    output logic [A_W+B_W-1:0] p_o
);

    localparam int PW = A_W + B_W;

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;

    assign a_x = {{B_W{sgn_i & a_i[A_W-1]}}, a_i};
    assign b_x = {{A_W{sgn_i & b_i[B_W-1]}}, b_i};
    assign p_o = a_x * b_x;

endmodule

// File: rtl/mult_pipe_elastic.sv
// Elastic valid/ready multiplier with runtime signed mode and multiply-accumulate.
// Slots 0..STAGES-2 carry the product for DSP retiming; the last slot does the accumulate add.
module mult_pipe_elastic
    import mult_pkg::slot_t;
    import mult_pkg::sext_to;
#(
    parameter int A_W    = mult_pkg::A_W,
    parameter int B_W    = mult_pkg::B_W,
    parameter int STAGES = 3,
    parameter int ACC_W  = mult_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_signed,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_p,
    output logic             out_ovf
);

    localparam int PW = A_W + B_W;

    logic [PW-1:0]     core_p;
    slot_t             in_slot;
    slot_t             src;
    logic              src_v;
    logic [STAGES-1:0] vld_q;
    logic [STAGES:0]   adv;
    logic [ACC_W-1:0]  acc_q;
    logic              ovf_q;
    logic [ACC_W-1:0]  addend;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_d;
    logic              ovf_d;

    mult_core #(.A_W(A_W), .B_W(B_W)) u_core (
        .a_i   (in_a),
        .b_i   (in_b),
        .sgn_i (in_signed),
        .p_o   (core_p)
    );

    always_comb begin
        in_slot      = '0;
        in_slot.prod = sext_to(core_p, in_signed);
        in_slot.sgn  = in_signed;
        in_slot.acc  = in_acc;
    end

    // Ready chain: a slot advances when empty or when its successor advances.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld_q[k] | adv[k+1];
        end
    end

    assign in_ready = reset_n & adv[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            if (adv[0]) vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) vld_q[k] <= vld_q[k-1];
            end
        end
    end

    if (STAGES == 1) begin : g_one
        assign src   = in_slot;
        assign src_v = in_valid;
    end else begin : g_pipe
        slot_t mid_q [STAGES-1];

        always_ff @(posedge clk) begin
            if (adv[0]) mid_q[0] <= in_slot;
            for (int k = 1; k < STAGES - 1; k++) begin
                if (adv[k]) mid_q[k] <= mid_q[k-1];
            end
        end

        assign src   = mid_q[STAGES-2];
        assign src_v = vld_q[STAGES-2];
    end

    // Overflow is judged per beat: two's complement in signed mode, carry out otherwise.
    always_comb begin
        addend = src.acc ? acc_q : '0;
        sum    = {1'b0, src.prod} + {1'b0, addend};
        acc_d  = sum[ACC_W-1:0];
        if (src.sgn) begin
            ovf_d = src.acc & (src.prod[ACC_W-1] == addend[ACC_W-1])
                            & (acc_d[ACC_W-1] != src.prod[ACC_W-1]);
        end else begin
            ovf_d = src.acc & sum[ACC_W];
        end
    end

    // The accumulator doubles as the output register: it always holds the last result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (adv[STAGES-1] && src_v) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_p     = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mult_pipe_elastic.sv
// Randomized and directed bench for mult_pipe_elastic against an arithmetic reference model.
module tb_mult_pipe_elastic;

    localparam int A_W    = 17;
    localparam int B_W    = 17;
    localparam int STAGES = 3;
    localparam int ACC_W  = 48;

    localparam longint SMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (ACC_W - 1));
    localparam longint UTOP = longint'(1) <<< ACC_W;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [A_W-1:0]   in_a      = '0;
    logic [B_W-1:0]   in_b      = '0;
    logic             in_signed = 1'b0;
    logic             in_acc    = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_p;
    logic             out_ovf;

    mult_pipe_elastic #(.A_W(A_W), .B_W(B_W), .STAGES(STAGES), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] p;
        logic             ovf;
        longint unsigned  t;
        bit               lit;
        logic [ACC_W-1:0] lp;
        logic             lovf;
    } exp_t;

    exp_t             q[$];
    int               n_cmp    = 0;
    int               n_bad    = 0;
    int               occ      = 0;
    longint unsigned  cyc      = 0;
    logic [ACC_W-1:0] macc     = '0;
    bit               started  = 0;
    bit               lat_mode = 0;
    bit               lit_en   = 0;
    logic [ACC_W-1:0] lit_p    = '0;
    logic             lit_ovf  = 1'b0;
    bit               rdy_mode = 0;
    logic             rdy_fixed = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer product plus optional previous result, then wrap.
    function automatic exp_t model(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                   input logic s, input logic ac, input logic [ACC_W-1:0] prev);
        exp_t   e;
        longint pa, pb, base, sum;
        pa   = s ? longint'($signed(a)) : longint'(a);
        pb   = s ? longint'($signed(b)) : longint'(b);
        base = !ac ? 0 : (s ? longint'($signed(prev)) : longint'(prev));
        sum  = pa * pb + base;
        e    = '{default: '0};
        e.p  = sum[ACC_W-1:0];
        e.ovf = ac && (s ? (sum > SMAX || sum < SMIN) : (sum >= UTOP));
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!reset_n) begin
            q.delete();
            macc = '0;
            occ  = 0;
        end else begin
            if (out_valid === 1'b1 && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                occ--;
            end
            if (in_valid && in_ready === 1'b1) begin
                e      = model(in_a, in_b, in_signed, in_acc, macc);
                e.t    = cyc;
                e.lit  = lit_en;
                e.lp   = lit_p;
                e.lovf = lit_ovf;
                macc   = e.p;
                q.push_back(e);
                occ++;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started && reset_n) begin
            chk("in_ready", in_ready, (occ < STAGES) || out_ready);
            if (out_valid !== 1'b0) begin
                if (q.size() == 0) begin
                    chk("out_valid_spurious", out_valid, 0);
                end else begin
                    chk("out_p", out_p, q[0].p);
                    chk("out_ovf", out_ovf, q[0].ovf);
                    if (q[0].lit) begin
                        chk("lit_p", out_p, q[0].lp);
                        chk("lit_ovf", out_ovf, q[0].lovf);
                    end
                    if (lat_mode) chk("latency", cyc - q[0].t, STAGES);
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end

    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic s,
                        input logic ac, input bit le, input logic [ACC_W-1:0] lp, input logic lo);
        int w;
        bit ok;
        w = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_acc = ac;
        lit_en = le; lit_p = lp; lit_ovf = lo;
        do begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
            @(posedge clk); #1;
            w++;
        end while (!ok && w < 200);
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        lit_en   = 0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (occ != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain", occ, 0);
    endtask

    initial begin
        #5_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int  n_bp;
        int  k;
        bit  ok;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        started = 1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // 1: reset with beats in flight
        rdy_fixed = 1'b0;
        send(7, 9, 0, 0, 0, 0, 0);
        send(4, 4, 0, 1, 0, 0, 0);
        send(3, 3, 0, 1, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        rdy_fixed = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_p", out_p, 0);
        chk("mid_rst_out_ovf", out_ovf, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        send(2, 3, 0, 1, 1, 48'd6, 0);
        drain();

        // 2: unsigned streaming, latency and throughput
        lat_mode = 1;
        send(17'h1FFFF, 17'h1FFFF, 0, 0, 1, 48'h3_FFFC_0001, 0);
        send(5, 7, 0, 0, 1, 48'd35, 0);
        drain();

        // 3: signed versus unsigned interpretation
        send(17'h1FFFF, 2, 1, 0, 1, 48'hFFFF_FFFF_FFFE, 0);
        send(17'h1FFFF, 2, 0, 0, 1, 48'h3FFFE, 0);
        drain();

        // 4: accumulate chain and restart
        send(3, 4, 0, 0, 1, 48'd12, 0);
        send(5, 6, 0, 1, 1, 48'd42, 0);
        send(1, 1, 0, 1, 1, 48'd43, 0);
        send(2, 2, 0, 0, 1, 48'd4, 0);
        drain();
        lat_mode = 0;

        // 5: backpressure fills exactly STAGES slots
        rdy_fixed = 1'b0;
        n_bp = 0;
        k    = 0;
        in_valid = 1'b1; in_a = 17'd10; in_b = 17'd3; in_signed = 1'b0; in_acc = 1'b0;
        repeat (10) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
            @(posedge clk); #1;
            if (ok) begin
                n_bp++;
                k++;
                in_a = A_W'(10 + k);
                in_b = B_W'(3 + k);
            end
        end
        in_valid = 1'b0;
        chk("bp_accepted", n_bp, STAGES);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rdy_fixed = 1'b1;
        for (int i = 0; i < 3; i++) send(A_W'(20 + i), B_W'(30 + i), 0, i[0], 0, 0, 0);
        drain();

        // 6: overflow, unsigned carry then signed positive overflow
        send(17'h1FFFF, 1, 1, 0, 1, 48'hFFFF_FFFF_FFFF, 0);
        send(1, 1, 0, 1, 1, 48'h0, 1);
        send(17'h10000, 17'h10000, 1, 0, 1, 48'h1_0000_0000, 0);
        for (int i = 0; i < 32766; i++) send(17'h10000, 17'h10000, 1, 1, 0, 0, 0);
        send(17'h0FFFF, 17'h0FFFF, 1, 1, 0, 0, 0);
        send(17'h0FFFF, 2, 1, 1, 1, 48'h7FFF_FFFF_FFFF, 0);
        send(1, 1, 1, 1, 1, 48'h8000_0000_0000, 1);
        drain();

        // Random traffic with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send(A_W'($urandom), B_W'($urandom), 1'($urandom),
                 ($urandom_range(0, 2) != 0), 0, 0, 0);
        end
        rdy_mode  = 0;
        rdy_fixed = 1'b1;
        drain();
        chk("final_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
